// File: rtl/calc_pkg.sv
// calc_pkg: operator codes, BCD blank code and converter state type shared across the calculator datapath
package calc_pkg;
    localparam logic [3:0] OP_PLUS  = 4'd10;
    localparam logic [3:0] OP_SUB   = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] BCD_BLANK = 4'hF;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_add3.sv
// bcd_add3: double-dabble digit adjust; d_i 4-bit digit in, q_o adjusted digit out
module bcd_add3 (
    input  logic [3:0] d_i,
    output logic [3:0] q_o
);
    assign q_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;
endmodule

// File: rtl/result_to_bcd.sv
// result_to_bcd: sequential double-dabble binary-to-BCD converter; in_valid/in_ready/result/sign in, out_valid/out_ready/bcd/bcd_sign/ndigits out; RESULT_TO_BCD_LZB_EN enables leading-zero blanking
module result_to_bcd
    import calc_pkg::*;
#(
    parameter int BCDdigits  = 2,
    parameter int OUT_DIGITS = (BCDdigits * 8 * 3) / 10 + 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BCDdigits*8-1:0]          result,
    input  logic                            sign,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_DIGITS*4-1:0]         bcd,
    output logic                            bcd_sign,
    output logic [$clog2(OUT_DIGITS+1)-1:0] ndigits
);
    localparam int W  = BCDdigits * 8;
    localparam int CW = $clog2(W + 1);
    localparam int NW = $clog2(OUT_DIGITS + 1);

    state_t                  state_q, state_d;
    logic [W-1:0]            bin_q, bin_d;
    logic [OUT_DIGITS*4-1:0] bcd_q, bcd_d, adj;
    logic                    sign_q, sign_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    for (genvar i = 0; i < OUT_DIGITS; i++) begin : g_adj
        bcd_add3 u_add3 (.d_i(bcd_q[i*4+:4]), .q_o(adj[i*4+:4]));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            sign_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        sign_d  = sign_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (in_valid) begin
                bin_d   = result;
                bcd_d   = '0;
                // a zero magnitude is never shown as negative
                sign_d  = sign & (|result);
                cnt_d   = CW'(W);
                state_d = SHIFT;
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = DONE;
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_sign  = sign_q;

`ifdef RESULT_TO_BCD_LZB_EN
    logic [OUT_DIGITS*4-1:0] blank;
    logic [NW-1:0]           nd;
    logic                    lz;
    always_comb begin
        nd    = NW'(1);
        lz    = 1'b1;
        blank = bcd_q;
        // digit 0 is always shown so zero displays as a single 0
        for (int k = OUT_DIGITS - 1; k > 0; k--) begin
            lz = lz & (bcd_q[k*4+:4] == 4'd0);
            if (lz) blank[k*4+:4] = BCD_BLANK;
            else if (nd == NW'(1)) nd = NW'(k + 1);
        end
    end
    assign bcd     = out_valid ? blank : bcd_q;
    assign ndigits = out_valid ? nd : NW'(OUT_DIGITS);
`else
    assign bcd     = bcd_q;
    assign ndigits = NW'(OUT_DIGITS);
`endif
endmodule
